// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous SRAM: VGA read port with fixed priority,
// DLA read/write port protected from starvation by a saturating grant counter.
module sram_arbiter #(
  parameter int SRAM_AW       = 20,
  parameter int SRAM_DW       = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               vga_req,
  input  logic [SRAM_AW-1:0] vga_addr,
  output logic               vga_ready,
  output logic               vga_rvalid,
  output logic [SRAM_DW-1:0] vga_rdata,
  input  logic               dla_req,
  input  logic               dla_write,
  input  logic [SRAM_AW-1:0] dla_addr,
  input  logic [SRAM_DW-1:0] dla_wdata,
  input  logic [1:0]         dla_be,
  output logic               dla_ready,
  output logic               dla_rvalid,
  output logic [SRAM_DW-1:0] dla_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [1:0]         sram_be_n
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0]    LAST_CYC   = 3'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               owner_dla_q, owner_dla_d;
  logic               write_q, write_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] wdata_q, wdata_d;
  logic [1:0]         be_q, be_d;
  logic               vga_rvalid_q, vga_rvalid_d;
  logic               dla_rvalid_q, dla_rvalid_d;
  logic [SRAM_DW-1:0] vga_rdata_q, vga_rdata_d;
  logic [SRAM_DW-1:0] dla_rdata_q, dla_rdata_d;
  logic               grant_dla;

  assign grant_dla = dla_req && (!vga_req || (starve_q == STARVE_MAX));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    owner_dla_d  = owner_dla_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    vga_rvalid_d = 1'b0;
    dla_rvalid_d = 1'b0;
    vga_rdata_d  = vga_rdata_q;
    dla_rdata_d  = dla_rdata_q;
    vga_ready    = 1'b0;
    dla_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sys_rst && grant_dla) begin
          dla_ready   = 1'b1;
          owner_dla_d = 1'b1;
          write_d     = dla_write;
          addr_d      = dla_addr;
          wdata_d     = dla_wdata;
          be_d        = dla_be;
          cnt_d       = 3'd0;
          starve_d    = '0;
          state_d     = ACCESS;
        end else if (!sys_rst && vga_req) begin
          vga_ready   = 1'b1;
          owner_dla_d = 1'b0;
          write_d     = 1'b0;
          addr_d      = vga_addr;
          be_d        = 2'b11;
          cnt_d       = 3'd0;
          state_d     = ACCESS;
          if (dla_req && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CYC) begin
          // Read data is captured on the closing edge of the final access cycle.
          if (write_q) begin
            state_d = TURN;
          end else begin
            state_d = IDLE;
            if (owner_dla_q) begin
              dla_rvalid_d = 1'b1;
              dla_rdata_d  = sram_dq;
            end else begin
              vga_rvalid_d = 1'b1;
              vga_rdata_d  = sram_dq;
            end
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!dla_req) starve_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      starve_q     <= '0;
      owner_dla_q  <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      vga_rvalid_q <= 1'b0;
      dla_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
      dla_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      owner_dla_q  <= owner_dla_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      vga_rvalid_q <= vga_rvalid_d;
      dla_rvalid_q <= dla_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
      dla_rdata_q  <= dla_rdata_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // Strobes decode purely from registered state, so they are stable for the whole cycle.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = 2'b11;
    if (state_q == ACCESS) begin
      sram_ce_n = 1'b0;
      if (write_q) begin
        sram_we_n = 1'b0;
        sram_be_n = ~be_q;
      end else begin
        sram_oe_n = 1'b0;
        sram_be_n = 2'b00;
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq    = ((state_q == ACCESS) && write_q) ? wdata_q : {SRAM_DW{1'bz}};
  assign vga_rvalid = vga_rvalid_q;
  assign vga_rdata  = vga_rdata_q;
  assign dla_rvalid = dla_rvalid_q;
  assign dla_rdata  = dla_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a small byte-maskable SRAM model sits on the
// shared bus and each scenario checks strobes, grants and read data cycle by cycle.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_ready;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          dla_req;
  logic          dla_write;
  logic [AW-1:0] dla_addr;
  logic [DW-1:0] dla_wdata;
  logic [1:0]    dla_be;
  logic          dla_ready;
  logic          dla_rvalid;
  logic [DW-1:0] dla_rdata;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [1:0]    sram_be_n;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  int contention = 0;

  sram_arbiter #(.SRAM_AW(AW), .SRAM_DW(DW), .ACCESS_CYCLES(2), .STARVE_LIMIT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ready(vga_ready),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .dla_req(dla_req), .dla_write(dla_write), .dla_addr(dla_addr),
    .dla_wdata(dla_wdata), .dla_be(dla_be), .dla_ready(dla_ready),
    .dla_rvalid(dla_rvalid), .dla_rdata(dla_rdata),
    .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 sys_clk = ~sys_clk;

  // SRAM model: drives the bus while selected and output-enabled; presets on reset.
  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'h5678;
      mem[8'h45] <= 16'h1200;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge sys_clk) begin
    if (!sram_oe_n && !sram_we_n) contention <= contention + 1;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; vga_req = 1'b1; dla_req = 1'b1;
    repeat (2) step();
    mid();
    checks++; if (vga_ready !== 1'b0) begin errors++; $display("FAIL rst_vga_ready: got %b want 0", vga_ready); end
    checks++; if (dla_ready !== 1'b0) begin errors++; $display("FAIL rst_dla_ready: got %b want 0", dla_ready); end
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin errors++; $display("FAIL rst_strobes: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    checks++; if (sram_be_n !== 2'b11) begin errors++; $display("FAIL rst_be_n: got %b want 11", sram_be_n); end
    checks++; if (sram_addr !== 20'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000", sram_addr); end
    checks++; if ({vga_rvalid, dla_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {vga_rvalid, dla_rvalid}); end
    checks++; if ({vga_rdata, dla_rdata} !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {vga_rdata, dla_rdata}); end
    sys_rst = 1'b0; vga_req = 1'b0; dla_req = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    vga_req = 1'b1; vga_addr = 20'h00010;
    mid();
    checks++; if (vga_ready !== 1'b1) begin errors++; $display("FAIL rd_vga_ready: got %b want 1", vga_ready); end
    checks++; if (dla_ready !== 1'b0) begin errors++; $display("FAIL rd_dla_ready: got %b want 0", dla_ready); end
    step(); vga_req = 1'b0; mid();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b001) begin errors++; $display("FAIL rd_strobes_t1: got %b want 001", {sram_ce_n, sram_oe_n, sram_we_n}); end
    checks++; if (sram_addr !== 20'h00010) begin errors++; $display("FAIL rd_addr: got %h want 00010", sram_addr); end
    checks++; if (sram_be_n !== 2'b00) begin errors++; $display("FAIL rd_be_n: got %b want 00", sram_be_n); end
    checks++; if (sram_dq !== 16'hBEEF) begin errors++; $display("FAIL rd_bus: got %h want beef", sram_dq); end
    step(); mid();
    checks++; if (sram_oe_n !== 1'b0) begin errors++; $display("FAIL rd_oe_t2: got %b want 0", sram_oe_n); end
    checks++; if (vga_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early: got %b want 0", vga_rvalid); end
    step(); mid();
    checks++; if (vga_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid_t3: got %b want 1", vga_rvalid); end
    checks++; if (vga_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata_t3: got %h want beef", vga_rdata); end
    checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL rd_oe_t3: got %b want 1", sram_oe_n); end
    step(); mid();
    checks++; if (vga_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse: got %b want 0", vga_rvalid); end
    checks++; if (vga_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata_hold: got %h want beef", vga_rdata); end
    step();
  endtask

  task automatic test_dla_write();
    dla_req = 1'b1; dla_write = 1'b1; dla_addr = 20'h12345; dla_wdata = 16'hA5A5; dla_be = 2'b01;
    mid();
    checks++; if (dla_ready !== 1'b1) begin errors++; $display("FAIL wr_dla_ready: got %b want 1", dla_ready); end
    step(); dla_req = 1'b0; mid();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b010) begin errors++; $display("FAIL wr_strobes_t1: got %b want 010", {sram_ce_n, sram_oe_n, sram_we_n}); end
    checks++; if (sram_be_n !== 2'b10) begin errors++; $display("FAIL wr_be_n: got %b want 10", sram_be_n); end
    checks++; if (sram_dq !== 16'hA5A5) begin errors++; $display("FAIL wr_bus: got %h want a5a5", sram_dq); end
    checks++; if (sram_addr !== 20'h12345) begin errors++; $display("FAIL wr_addr: got %h want 12345", sram_addr); end
    step(); mid();
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL wr_we_t2: got %b want 0", sram_we_n); end
    step(); mid();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 5'b11111) begin errors++; $display("FAIL wr_turn_strobes: got %b want 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}); end
    checks++; if (sram_addr !== 20'h12345) begin errors++; $display("FAIL wr_turn_addr_hold: got %h want 12345", sram_addr); end
    checks++; if (dla_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", dla_rvalid); end
    step(); mid();
    checks++; if (mem[8'h45] !== 16'h12A5) begin errors++; $display("FAIL wr_mem_bytes: got %h want 12a5", mem[8'h45]); end
    checks++; if (dla_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid_late: got %b want 0", dla_rvalid); end
    step();
  endtask

  task automatic test_simultaneous();
    vga_req = 1'b1; vga_addr = 20'h00010;
    dla_req = 1'b1; dla_write = 1'b0; dla_addr = 20'h00020;
    mid();
    checks++; if ({vga_ready, dla_ready} !== 2'b10) begin errors++; $display("FAIL sim_grant: got %b want 10", {vga_ready, dla_ready}); end
    step(); vga_req = 1'b0; mid();
    checks++; if (dla_ready !== 1'b0) begin errors++; $display("FAIL sim_busy_ready: got %b want 0", dla_ready); end
    step(); step(); mid();
    checks++; if (dla_ready !== 1'b1) begin errors++; $display("FAIL sim_dla_grant: got %b want 1", dla_ready); end
    checks++; if (vga_rdata !== 16'hBEEF) begin errors++; $display("FAIL sim_vga_rdata: got %h want beef", vga_rdata); end
    step(); dla_req = 1'b0;
    step(); step(); mid();
    checks++; if (dla_rvalid !== 1'b1) begin errors++; $display("FAIL sim_dla_rvalid: got %b want 1", dla_rvalid); end
    checks++; if (dla_rdata !== 16'h5678) begin errors++; $display("FAIL sim_dla_rdata: got %h want 5678", dla_rdata); end
    step();
  endtask

  task automatic test_starve();
    int n = 0;
    logic [9:0] who = '0;
    vga_req = 1'b1; vga_addr = 20'h00010;
    dla_req = 1'b1; dla_write = 1'b0; dla_addr = 20'h00020;
    for (int c = 0; c < 100 && n < 10; c++) begin
      mid();
      if (dla_ready) begin who[n] = 1'b1; n++; end
      else if (vga_ready) begin who[n] = 1'b0; n++; end
      step();
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL starve_grant_count: got %0d want 10", n); end
    checks++; if (who !== 10'b01_0000_0000) begin errors++; $display("FAIL starve_order: got %b want 0100000000", who); end
    vga_req = 1'b0; dla_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_write_then_read();
    dla_req = 1'b1; dla_write = 1'b1; dla_addr = 20'h12345; dla_wdata = 16'hC3C3; dla_be = 2'b11;
    mid();
    checks++; if (dla_ready !== 1'b1) begin errors++; $display("FAIL wtr_dla_ready: got %b want 1", dla_ready); end
    step(); dla_req = 1'b0; vga_req = 1'b1; vga_addr = 20'h12345; mid();
    checks++; if (vga_ready !== 1'b0) begin errors++; $display("FAIL wtr_busy_ready: got %b want 0", vga_ready); end
    step(); step(); mid();
    checks++; if (vga_ready !== 1'b0) begin errors++; $display("FAIL wtr_turn_ready: got %b want 0", vga_ready); end
    checks++; if ({sram_oe_n, sram_we_n} !== 2'b11) begin errors++; $display("FAIL wtr_turn_strobes: got %b want 11", {sram_oe_n, sram_we_n}); end
    step(); mid();
    checks++; if (vga_ready !== 1'b1) begin errors++; $display("FAIL wtr_read_grant: got %b want 1", vga_ready); end
    step(); vga_req = 1'b0; mid();
    checks++; if ({sram_oe_n, sram_we_n} !== 2'b01) begin errors++; $display("FAIL wtr_read_strobes: got %b want 01", {sram_oe_n, sram_we_n}); end
    step(); step(); mid();
    checks++; if (vga_rvalid !== 1'b1) begin errors++; $display("FAIL wtr_rvalid: got %b want 1", vga_rvalid); end
    checks++; if (vga_rdata !== 16'hC3C3) begin errors++; $display("FAIL wtr_rdata: got %h want c3c3", vga_rdata); end
    checks++; if (contention !== 0) begin errors++; $display("FAIL wtr_contention: got %0d want 0", contention); end
    step();
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    vga_req = 1'b1; vga_addr = 20'h00010;
    mid();
    checks++; if (vga_ready !== 1'b1) begin errors++; $display("FAIL rmr_grant: got %b want 1", vga_ready); end
    step(); vga_req = 1'b0; sys_rst = 1'b1; mid();
    checks++; if (sram_oe_n !== 1'b0) begin errors++; $display("FAIL rmr_in_access: got %b want 0", sram_oe_n); end
    step(); sys_rst = 1'b0; mid();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin errors++; $display("FAIL rmr_strobes: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    checks++; if (vga_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_rvalid: got %b want 0", vga_rvalid); end
    checks++; if (vga_rdata !== 16'h0) begin errors++; $display("FAIL rmr_rdata_cleared: got %h want 0000", vga_rdata); end
    repeat (3) begin step(); mid(); if (vga_rvalid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmr_late_rvalid: got %0d want 0", seen); end
    step(); vga_req = 1'b1; mid();
    checks++; if (vga_ready !== 1'b1) begin errors++; $display("FAIL rmr_regrant: got %b want 1", vga_ready); end
    step(); vga_req = 1'b0; step(); step(); mid();
    checks++; if (vga_rvalid !== 1'b1) begin errors++; $display("FAIL rmr_rvalid_after: got %b want 1", vga_rvalid); end
    checks++; if (vga_rdata !== 16'hBEEF) begin errors++; $display("FAIL rmr_rdata_after: got %h want beef", vga_rdata); end
    step();
  endtask

  initial begin
    sys_rst = 1'b1; vga_req = 1'b0; vga_addr = '0;
    dla_req = 1'b0; dla_write = 1'b0; dla_addr = '0; dla_wdata = '0; dla_be = 2'b00;
    test_reset();
    test_single_read();
    test_dla_write();
    test_simultaneous();
    test_starve();
    test_write_then_read();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): SRAM_AW, 20, SRAM address width.
REQ-002 SHALL have parameter SRAM_DW, 16, SRAM data width.
REQ-003 SHALL have parameter ACCESS_CYCLES, 2, cycles SRAM pins are held per access; legal range 1-8.
REQ-004 SHALL have parameter STARVE_LIMIT, 8, consecutive VGA grants allowed while a DLA request waits.
REQ-005 SHALL have ports, listed as name, direction, width, meaning:
- sys_clk, in, 1: sole clock.
- sys_rst, in, 1: synchronous, active-high reset.
- vga_req, in, 1: VGA read request.
- vga_addr, in, SRAM_AW: VGA read address.
- vga_ready, out, 1: VGA request accepted this cycle.
- vga_rvalid, out, 1: VGA read data valid, one-cycle pulse.
- vga_rdata, out, SRAM_DW: VGA read data.
- dla_req, in, 1: DLA request.
- dla_write, in, 1: 1 = write, 0 = read.
- dla_addr, in, SRAM_AW: DLA address.
- dla_wdata, in, SRAM_DW: DLA write data.
- dla_be, in, 2: DLA byte enables, active-high, [1] = upper byte.
- dla_ready, out, 1: DLA request accepted this cycle.
- dla_rvalid, out, 1: DLA read data valid, one-cycle pulse.
- dla_rdata, out, SRAM_DW: DLA read data.
- sram_addr, out, SRAM_AW: SRAM address.
- sram_dq, inout, SRAM_DW: SRAM data bus.
- sram_ce_n, out, 1: SRAM chip enable.
- sram_oe_n, out, 1: SRAM output enable.
- sram_we_n, out, 1: SRAM write enable.
- sram_be_n, out, 2: SRAM byte masks, [1] = UB, [0] = LB.

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, TURN.
REQ-007 In IDLE, SHALL accept at most one request per cycle; xxx_ready is combinational and asserted only in IDLE, only for the selected requester, and only when its xxx_req is high.
REQ-008 Arbitration SHALL be fixed priority to VGA, except DLA wins when dla_req = 1 and the starve counter = STARVE_LIMIT.
REQ-009 Starve counter SHALL increment on each VGA grant made while dla_req = 1, clear on any DLA grant or when dla_req = 0, and saturate at STARVE_LIMIT.
REQ-010 On acceptance at cycle T, SHALL latch address, direction, wdata and byte enables, and enter ACCESS at T+1 for exactly ACCESS_CYCLES cycles.
REQ-011 During ACCESS, sram_addr, sram_ce_n = 0 and sram_be_n SHALL be driven from registers.
- Reads: sram_be_n = 2'b00, sram_oe_n = 0, sram_we_n = 1, sram_dq released (high-Z).
- Writes: sram_be_n = ~be, sram_oe_n = 1, sram_we_n = 0, sram_dq driven with wdata.
REQ-012 For reads, SHALL sample sram_dq at the last ACCESS cycle edge, and pulse the owner's xxx_rvalid for one cycle at T+1+ACCESS_CYCLES with xxx_rdata holding the sample; rdata holds its value until the next read for that owner.
REQ-013 After a read, SHALL return to IDLE. After a write, SHALL enter TURN for one cycle (all strobes inactive, dq high-Z), then IDLE.
REQ-014 In IDLE and TURN, SHALL drive sram_ce_n = sram_oe_n = sram_we_n = 1 and sram_be_n = 2'b11; sram_addr holds its last value.
REQ-015 sram_dq SHALL never be driven in the same cycle sram_oe_n = 0.
REQ-016 Request inputs sampled only at acceptance; changes during ACCESS SHALL NOT affect the current access.
REQ-017 Writes SHALL NOT assert any rvalid.
REQ-018 Read throughput SHALL be one access per ACCESS_CYCLES + 1 cycles; write throughput one per ACCESS_CYCLES + 2.

Reset
REQ-019 While sys_rst = 1 at an edge, SHALL go to IDLE and set:
- sram_ce_n = sram_oe_n = sram_we_n = 1, sram_be_n = 2'b11, sram_addr = 0, sram_dq high-Z.
- vga_rvalid = dla_rvalid = 0, vga_rdata = dla_rdata = 0.
- starve counter = 0.
REQ-020 vga_ready and dla_ready SHALL be 0 during reset.
REQ-021 Reset during ACCESS SHALL abort the access with no rvalid pulse and strobes inactive on the next cycle.

Verification
REQ-022 Single read: vga_req, vga_addr = 0x00010, SRAM model returns 0xBEEF -> vga_ready at T; oe_n low T+1..T+2; vga_rvalid at T+3 with 0xBEEF.
REQ-023 DLA write: addr 0x12345, wdata 0xA5A5, be = 2'b01 -> we_n low 2 cycles, sram_be_n = 2'b10, TURN cycle, model holds only low byte 0xA5.
REQ-024 Simultaneous vga_req and dla_req in IDLE -> VGA granted, dla_ready = 0 that cycle, DLA granted next IDLE when vga_req = 0.
REQ-025 vga_req held high, dla_req high -> 8 VGA grants, 9th grant to DLA, then counter 0.
REQ-026 Write then immediate read -> one TURN cycle; dq high-Z before oe_n falls; no bus-contention cycle.
REQ-027 sys_rst asserted mid-read -> no rvalid; all strobes high next cycle; next request served normally.
